// File: rtl/mem_stage_dm.sv
// mem_stage_dm: MEM stage of the 5-stage MIPS pipeline together with the MEM/WB register.
// Performs byte/half/word stores into a word-organised data RAM, extracts and extends
// load data, flags misaligned and out-of-range accesses, and registers every WB value.
module mem_stage_dm #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        regWriteM,
    input  logic        memToRegM,
    input  logic        memWriteM,
    input  logic        jalOpM,
    input  logic [2:0]  memOpM,
    input  logic [31:0] aluOutM,
    input  logic [31:0] writeDataM,
    input  logic [4:0]  writeRegM,
    input  logic [31:0] pcM,
    input  logic [1:0]  TnewM,
    output logic        regWriteW,
    output logic        memToRegW,
    output logic        jalOpW,
    output logic [31:0] aluOutW,
    output logic [31:0] readDataW,
    output logic [4:0]  writeRegW,
    output logic [31:0] pcW,
    output logic [1:0]  TnewW,
    output logic [1:0]  errW
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]       r_ram [DEPTH];

    logic [31:0]       w_offset;
    logic [ADDR_W-1:0] w_widx;
    logic              w_memAccess;
    logic              w_isHalf;
    logic              w_isByte;
    logic              w_isWord;
    logic              w_isSigned;
    logic              w_misaligned;
    logic              w_rangeErr;
    logic [1:0]        w_err;
    logic [3:0]        w_byteEn;
    logic [31:0]       w_storeData;
    logic [31:0]       w_ramWord;
    logic [15:0]       w_halfSel;
    logic [7:0]        w_byteSel;
    logic [31:0]       w_loadData;

    assign w_offset    = aluOutM - BASE_ADDR;
    assign w_widx      = w_offset[ADDR_W+1:2];
    assign w_memAccess = memToRegM | memWriteM;
    assign w_err       = {w_rangeErr, w_misaligned};
    assign w_ramWord   = r_ram[w_widx];

    // Decode the access size (codes 5..7 fall back to word) and detect access errors.
    always_comb begin
        w_isHalf     = (memOpM == 3'd1) || (memOpM == 3'd2);
        w_isByte     = (memOpM == 3'd3) || (memOpM == 3'd4);
        w_isWord     = !w_isHalf && !w_isByte;
        w_isSigned   = (memOpM == 3'd1) || (memOpM == 3'd3);
        w_misaligned = w_memAccess &&
                       ((w_isWord && (w_offset[1:0] != 2'd0)) || (w_isHalf && w_offset[0]));
        w_rangeErr   = w_memAccess && ((w_offset >> (ADDR_W + 2)) != 32'd0);
    end

    // Build the lane enables and lane-replicated store data for a byte-enable write.
    always_comb begin
        w_byteEn    = 4'hF;
        w_storeData = writeDataM;
        if (w_isHalf) begin
            w_byteEn    = w_offset[1] ? 4'b1100 : 4'b0011;
            w_storeData = {2{writeDataM[15:0]}};
        end else if (w_isByte) begin
            w_byteEn    = 4'b0001 << w_offset[1:0];
            w_storeData = {4{writeDataM[7:0]}};
        end
    end

    // Select the addressed lane of the read word and extend it; erroneous or non-loads give 0.
    always_comb begin
        w_halfSel  = w_offset[1] ? w_ramWord[31:16] : w_ramWord[15:0];
        w_byteSel  = w_ramWord[7:0];
        case (w_offset[1:0])
            2'd1:    w_byteSel = w_ramWord[15:8];
            2'd2:    w_byteSel = w_ramWord[23:16];
            2'd3:    w_byteSel = w_ramWord[31:24];
            default: w_byteSel = w_ramWord[7:0];
        endcase
        w_loadData = 32'd0;
        if (memToRegM && (w_err == 2'b00)) begin
            if (w_isHalf) begin
                w_loadData = w_isSigned ? {{16{w_halfSel[15]}}, w_halfSel} : {16'd0, w_halfSel};
            end else if (w_isByte) begin
                w_loadData = w_isSigned ? {{24{w_byteSel[7]}}, w_byteSel} : {24'd0, w_byteSel};
            end else begin
                w_loadData = w_ramWord;
            end
        end
    end

    // Data RAM: cleared by reset, written lane-by-lane at the edge ending an error-free store.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ram[i] <= 32'd0;
            end
        end else if (memWriteM && (w_err == 2'b00)) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byteEn[b]) begin
                    r_ram[w_widx][8*b +: 8] <= w_storeData[8*b +: 8];
                end
            end
        end
    end

    // MEM/WB register: captured every edge, no stall or flush; errors suppress the write-back.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regWriteW <= 1'b0;
            memToRegW <= 1'b0;
            jalOpW    <= 1'b0;
            aluOutW   <= 32'd0;
            readDataW <= 32'd0;
            writeRegW <= 5'd0;
            pcW       <= 32'd0;
            TnewW     <= 2'd0;
            errW      <= 2'd0;
        end else begin
            regWriteW <= regWriteM && (w_err == 2'b00);
            memToRegW <= memToRegM;
            jalOpW    <= jalOpM;
            aluOutW   <= aluOutM;
            readDataW <= w_loadData;
            writeRegW <= writeRegM;
            pcW       <= pcM;
            TnewW     <= (TnewM == 2'd0) ? 2'd0 : (TnewM - 2'd1);
            errW      <= w_err;
        end
    end

endmodule

// File: tb/tb_mem_stage_dm.sv
// tb_mem_stage_dm: drives directed and random MEM-stage traffic and compares the WB outputs
// with a byte-addressed memory model evaluated from the access rules.
module tb_mem_stage_dm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        regWriteM, memToRegM, memWriteM, jalOpM;
    logic [2:0]  memOpM;
    logic [31:0] aluOutM, writeDataM, pcM;
    logic [4:0]  writeRegM;
    logic [1:0]  TnewM;
    logic        regWriteW, memToRegW, jalOpW;
    logic [31:0] aluOutW, readDataW, pcW;
    logic [4:0]  writeRegW;
    logic [1:0]  TnewW, errW;

    typedef struct packed {
        logic        regWrite;
        logic        memToReg;
        logic        jalOp;
        logic [31:0] aluOut;
        logic [31:0] readData;
        logic [4:0]  writeReg;
        logic [31:0] pc;
        logic [1:0]  tnew;
        logic [1:0]  err;
    } wbT;

    int   total = 0;
    int   bad   = 0;
    wbT   cur;
    logic curValid = 1'b0;
    logic [7:0] mb [0:4095];

    mem_stage_dm #(.ADDR_W(10), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset_n(reset_n),
        .regWriteM(regWriteM), .memToRegM(memToRegM), .memWriteM(memWriteM), .jalOpM(jalOpM),
        .memOpM(memOpM), .aluOutM(aluOutM), .writeDataM(writeDataM), .writeRegM(writeRegM),
        .pcM(pcM), .TnewM(TnewM),
        .regWriteW(regWriteW), .memToRegW(memToRegW), .jalOpW(jalOpW), .aluOutW(aluOutW),
        .readDataW(readDataW), .writeRegW(writeRegW), .pcW(pcW), .TnewW(TnewW), .errW(errW)
    );

    // Free-running pipeline clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every registered output with the model on each cycle the outputs are meaningful.
    always @(negedge clk) begin
        if (curValid && reset_n) begin
            checkOutput("regWriteW", 32'(regWriteW), 32'(cur.regWrite));
            checkOutput("memToRegW", 32'(memToRegW), 32'(cur.memToReg));
            checkOutput("jalOpW",    32'(jalOpW),    32'(cur.jalOp));
            checkOutput("aluOutW",   aluOutW,        cur.aluOut);
            checkOutput("readDataW", readDataW,      cur.readData);
            checkOutput("writeRegW", 32'(writeRegW), 32'(cur.writeReg));
            checkOutput("pcW",       pcW,            cur.pc);
            checkOutput("TnewW",     32'(TnewW),     32'(cur.tnew));
            checkOutput("errW",      32'(errW),      32'(cur.err));
        end
    end

    // Model: a little-endian byte array; loads read before stores write.
    task automatic applyModel(output wbT r);
        logic [31:0] off;
        logic [31:0] ld;
        logic        acc, mis, rng;
        int          size;
        off  = aluOutM;
        acc  = memToRegM | memWriteM;
        size = (memOpM == 3'd1 || memOpM == 3'd2) ? 2 : ((memOpM == 3'd3 || memOpM == 3'd4) ? 1 : 4);
        mis  = acc && ((off % 32'(size)) != 32'd0);
        rng  = acc && (off >= 32'd4096);
        ld   = 32'd0;
        if (memToRegM && !mis && !rng) begin
            for (int k = 0; k < size; k++) ld = ld | (32'(mb[off + 32'(k)]) << (8 * k));
            if (memOpM == 3'd1 && ld[15]) ld = ld | 32'hFFFF_0000;
            if (memOpM == 3'd3 && ld[7])  ld = ld | 32'hFFFF_FF00;
        end
        if (memWriteM && !mis && !rng) begin
            for (int k = 0; k < size; k++) mb[off + 32'(k)] = writeDataM[8*k +: 8];
        end
        r.regWrite = regWriteM && !mis && !rng;
        r.memToReg = memToRegM;
        r.jalOp    = jalOpM;
        r.aluOut   = aluOutM;
        r.readData = ld;
        r.writeReg = writeRegM;
        r.pc       = pcM;
        r.tnew     = (TnewM == 2'd0) ? 2'd0 : TnewM - 2'd1;
        r.err      = {rng, mis};
    endtask

    task automatic setIns(input logic rw, input logic mr, input logic mw, input logic jal,
                          input logic [2:0] op, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] wr, input logic [31:0] pc, input logic [1:0] tn);
        regWriteM = rw; memToRegM = mr; memWriteM = mw; jalOpM = jal; memOpM = op;
        aluOutM = alu; writeDataM = wd; writeRegM = wr; pcM = pc; TnewM = tn;
    endtask

    // Evaluate the model for the current inputs, then let one edge capture them.
    task automatic applyStimulus();
        wbT p;
        applyModel(p);
        @(posedge clk);
        cur = p;
        curValid = 1'b1;
        #1;
    endtask

    task automatic doLoad(input logic [2:0] op, input logic [31:0] addr);
        setIns(1'b1, 1'b1, 1'b0, 1'b0, op, addr, 32'h5A5A_5A5A, 5'd8, 32'h400, 2'd2);
        applyStimulus();
    endtask

    task automatic doStore(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
        setIns(1'b0, 1'b0, 1'b1, 1'b0, op, addr, data, 5'd0, 32'h404, 2'd0);
        applyStimulus();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".regWriteW"}, 32'(regWriteW), 32'd0);
        checkOutput({tag, ".readDataW"}, readDataW, 32'd0);
        checkOutput({tag, ".aluOutW"},   aluOutW,   32'd0);
        checkOutput({tag, ".pcW"},       pcW,       32'd0);
        checkOutput({tag, ".misc"},
                    32'({memToRegW, jalOpW, writeRegW, TnewW, errW}), 32'd0);
    endtask

    // Assert reset mid-cycle, check outputs clear at once and stay clear across an edge.
    task automatic doReset();
        #2;
        reset_n  = 1'b0;
        curValid = 1'b0;
        #1;
        checkAllZero("resetNow");
        for (int i = 0; i < 4096; i++) mb[i] = 8'd0;
        @(posedge clk);
        #1;
        checkAllZero("resetHold");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b1;
        setIns(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 32'd0, 2'd0);
        @(posedge clk);
        doReset();

        doLoad(3'd0, 32'h0);
        checkOutput("lwAfterReset", readDataW, 32'h0);

        doStore(3'd0, 32'h10, 32'hDEAD_BEEF);
        doLoad(3'd0, 32'h10);
        checkOutput("lwWord", readDataW, 32'hDEAD_BEEF);
        checkOutput("lwWordErr", 32'(errW), 32'd0);

        doStore(3'd3, 32'h21, 32'h0000_0080);
        doStore(3'd1, 32'h22, 32'h0000_1234);
        doLoad(3'd0, 32'h20);
        checkOutput("ramWord8", readDataW, 32'h1234_8000);
        doLoad(3'd3, 32'h21);
        checkOutput("lb", readDataW, 32'hFFFF_FF80);
        doLoad(3'd4, 32'h21);
        checkOutput("lbu", readDataW, 32'h0000_0080);
        doLoad(3'd1, 32'h22);
        checkOutput("lh", readDataW, 32'h0000_1234);

        doStore(3'd0, 32'h13, 32'hCAFE_F00D);
        checkOutput("swMisErr", 32'(errW), 32'd1);
        doLoad(3'd1, 32'h15);
        checkOutput("lhMisErr", 32'(errW), 32'd1);
        checkOutput("lhMisRegWrite", 32'(regWriteW), 32'd0);
        checkOutput("lhMisData", readDataW, 32'd0);
        doLoad(3'd0, 32'h10);
        checkOutput("ramUnchanged", readDataW, 32'hDEAD_BEEF);

        doStore(3'd0, 32'h1000, 32'h1111_2222);
        checkOutput("swRangeErr", 32'(errW), 32'd2);
        doLoad(3'd0, 32'h0);
        checkOutput("noAliasWrite", readDataW, 32'd0);
        setIns(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'h1000, 32'h0, 5'd3, 32'h408, 2'd1);
        applyStimulus();
        checkOutput("addErr", 32'(errW), 32'd0);
        checkOutput("addAlu", aluOutW, 32'h1000);
        checkOutput("addRegWrite", 32'(regWriteW), 32'd1);

        setIns(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'h3008, 32'h0, 5'd31, 32'h3000, 2'd2);
        applyStimulus();
        checkOutput("jalPc", pcW, 32'h3000);
        checkOutput("jalReg", 32'(writeRegW), 32'd31);
        checkOutput("jalOp", 32'(jalOpW), 32'd1);
        checkOutput("jalTnew", 32'(TnewW), 32'd1);
        TnewM = 2'd0;
        applyStimulus();
        checkOutput("tnew0", 32'(TnewW), 32'd0);
        TnewM = 2'd3;
        applyStimulus();
        checkOutput("tnew3", 32'(TnewW), 32'd2);

        setIns(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 32'h10, 32'h0BAD_F00D, 5'd4, 32'h40C, 2'd2);
        applyStimulus();
        checkOutput("rbwOld", readDataW, 32'hDEAD_BEEF);
        doLoad(3'd0, 32'h10);
        checkOutput("rbwNew", readDataW, 32'h0BAD_F00D);

        doStore(3'd0, 32'h40, 32'h7777_7777);
        setIns(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'h44, 32'h9999_9999, 5'd0, 32'h410, 2'd0);
        doReset();
        doLoad(3'd0, 32'h44);
        checkOutput("resetDiscardsStore", readDataW, 32'd0);
        doLoad(3'd0, 32'h40);
        checkOutput("resetClearsRam", readDataW, 32'd0);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] addr;
            int          kind;
            kind = int'($urandom_range(0, 9));
            addr = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? $urandom() : $urandom_range(0, 32'h1FFF))
                                               : $urandom_range(0, 95);
            setIns(1'($urandom()), (kind < 4) || (kind == 9), (kind >= 4 && kind < 8) || (kind == 9),
                   1'($urandom()), 3'($urandom()), addr, $urandom(), 5'($urandom()),
                   $urandom(), 2'($urandom()));
            applyStimulus();
        end

        @(negedge clk);
        curValid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
